// File: rtl/cpu_pkg.sv
// cpu_pkg: fetch-stage state encoding and PC increment shared with the fetch/decode register.
package cpu_pkg;
  typedef enum logic [1:0] {IDLE, REQ, HALT} pc_state_t;
  localparam int PC_INCR = 4;
endpackage

// File: rtl/adder.sv
// adder: n-bit modular adder used for sequential PC advance.
module adder #(
  parameter int n = 32
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic [n-1:0] y
);
  assign y = a + b;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-address sequencer with req/ack memory handshake and deferred redirects.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int           n        = 32,
  parameter logic [n-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         halt,
  input  logic         branch_taken,
  input  logic [n-1:0] branch_target,
  input  logic         jump,
  input  logic [n-1:0] jump_target,
  input  logic         imem_ack,
  output logic         imem_req,
  output logic [n-1:0] pc,
  output logic         fetch_done,
  output logic [n-1:0] fetch_pc,
  output logic         halted,
  output logic         misalign_err
);
  pc_state_t    state_q, state_d;
  logic [n-1:0] pc_q, pc_d, pc_sum;
  logic [n-1:0] pend_tgt_q, pend_tgt_d;
  logic         pend_q, pend_d;
  logic         halt_pend_q, halt_pend_d;
  logic         fetch_done_q, fetch_done_d;
  logic [n-1:0] fetch_pc_q, fetch_pc_d;
  logic         misalign_q, misalign_d;
  logic         redir;
  logic [n-1:0] raw_tgt, tgt;
  adder #(.n(n)) u_adder (
    .a(pc_q),
    .b(n'(PC_INCR)),
    .y(pc_sum)
  );
  always_comb begin
    redir        = jump | branch_taken;
    raw_tgt      = jump ? jump_target : branch_target;
    tgt          = {raw_tgt[n-1:2], 2'b00};
    state_d      = state_q;
    pc_d         = pc_q;
    pend_d       = pend_q;
    pend_tgt_d   = pend_tgt_q;
    halt_pend_d  = halt_pend_q;
    fetch_done_d = 1'b0;
    fetch_pc_d   = fetch_pc_q;
    misalign_d   = misalign_q | (redir && state_q != HALT && |raw_tgt[1:0]);
    case (state_q)
      IDLE: begin
        pc_d    = redir ? tgt : pc_q;
        state_d = halt ? HALT : stall ? IDLE : REQ;
      end
      REQ: begin
        if (imem_ack) begin
          // A redirect seen during this fetch squashes it; the live one beats the held one.
          pc_d         = redir ? tgt : pend_q ? pend_tgt_q : pc_sum;
          fetch_done_d = !redir && !pend_q;
          fetch_pc_d   = (!redir && !pend_q) ? pc_q : fetch_pc_q;
          pend_d       = 1'b0;
          halt_pend_d  = 1'b0;
          state_d      = (halt || halt_pend_q) ? HALT : stall ? IDLE : REQ;
        end else begin
          pend_d      = pend_q | redir;
          pend_tgt_d  = redir ? tgt : pend_tgt_q;
          halt_pend_d = halt_pend_q | halt;
        end
      end
      default: state_d = HALT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      pend_q       <= 1'b0;
      pend_tgt_q   <= '0;
      halt_pend_q  <= 1'b0;
      fetch_done_q <= 1'b0;
      fetch_pc_q   <= '0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_q       <= pend_d;
      pend_tgt_q   <= pend_tgt_d;
      halt_pend_q  <= halt_pend_d;
      fetch_done_q <= fetch_done_d;
      fetch_pc_q   <= fetch_pc_d;
      misalign_q   <= misalign_d;
    end
  end
  assign imem_req     = state_q == REQ;
  assign halted       = state_q == HALT;
  assign pc           = pc_q;
  assign fetch_done   = fetch_done_q;
  assign fetch_pc     = fetch_pc_q;
  assign misalign_err = misalign_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench; expected fetch_pc values queued at each completing ack.
module tb_pc_sequencer;
  logic        clk = 1'b0;
  logic        reset, stall, halt, branch_taken, jump, imem_ack;
  logic [31:0] branch_target, jump_target;
  logic        imem_req, fetch_done, halted, misalign_err;
  logic [31:0] pc, fetch_pc;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  pc_sequencer #(.n(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .stall(stall), .halt(halt),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .imem_ack(imem_ack),
    .imem_req(imem_req), .pc(pc), .fetch_done(fetch_done),
    .fetch_pc(fetch_pc), .halted(halted), .misalign_err(misalign_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  always @(posedge clk) begin
    #2;
    if (fetch_done) begin
      if (exp_q.size() == 0) chk("spurious_fetch_done", 32'(fetch_done), 32'd0);
      else chk("fetch_pc", fetch_pc, exp_q.pop_front());
    end
  end
  initial begin
    reset = 1; stall = 0; halt = 0; branch_taken = 0; jump = 0; imem_ack = 0;
    branch_target = 0; jump_target = 0;
    step(); step();
    chk("rst_pc", pc, 32'h0);
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_fd", 32'(fetch_done), 0);
    chk("rst_fpc", fetch_pc, 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_mis", 32'(misalign_err), 0);
    // zero-wait memory: one fetch per cycle
    reset = 0; imem_ack = 1;
    step();
    chk("first_req", 32'(imem_req), 1);
    for (int i = 0; i < 3; i++) begin
      chk("seq_pc", pc, 32'(4 * i));
      exp_q.push_back(32'(4 * i));
      step();
      chk("seq_fd", 32'(fetch_done), 1);
    end
    imem_ack = 0;
    chk("seq_pc3", pc, 32'hC);
    // stall during a request
    stall = 1;
    step();
    chk("stall_req_hold", 32'(imem_req), 1);
    chk("stall_pc_hold", pc, 32'hC);
    imem_ack = 1; exp_q.push_back(32'hC);
    step();
    imem_ack = 0;
    chk("stall_idle_req", 32'(imem_req), 0);
    chk("stall_idle_pc", pc, 32'h10);
    step();
    chk("stall_idle_req2", 32'(imem_req), 0);
    stall = 0;
    step();
    chk("unstall_req", 32'(imem_req), 1);
    // branch during a delayed ack: held, then squashes this fetch
    branch_taken = 1; branch_target = 32'h100;
    step();
    branch_taken = 0;
    chk("pend_pc_w1", pc, 32'h10);
    step();
    chk("pend_pc_w2", pc, 32'h10);
    step();
    chk("pend_pc_w3", pc, 32'h10);
    imem_ack = 1;
    step();
    imem_ack = 0;
    chk("pend_redir_pc", pc, 32'h100);
    chk("pend_squash", 32'(fetch_done), 0);
    chk("pend_req", 32'(imem_req), 1);
    // jump beats branch in the ack cycle
    jump = 1; jump_target = 32'h200; branch_taken = 1; branch_target = 32'h300; imem_ack = 1;
    step();
    jump = 0; branch_taken = 0;
    chk("jmp_pc", pc, 32'h200);
    chk("jmp_squash", 32'(fetch_done), 0);
    // misaligned branch target
    branch_taken = 1; branch_target = 32'h102;
    step();
    branch_taken = 0; imem_ack = 0;
    chk("mis_pc", pc, 32'h100);
    chk("mis_flag", 32'(misalign_err), 1);
    step(); step();
    chk("mis_sticky", 32'(misalign_err), 1);
    imem_ack = 1; exp_q.push_back(32'h100);
    step();
    imem_ack = 0;
    chk("post_mis_pc", pc, 32'h104);
    // wraparound
    jump = 1; jump_target = 32'hFFFF_FFFC; imem_ack = 1;
    step();
    jump = 0;
    chk("wrap_start", pc, 32'hFFFF_FFFC);
    exp_q.push_back(32'hFFFF_FFFC);
    step();
    imem_ack = 0;
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_fpc", fetch_pc, 32'hFFFF_FFFC);
    // halt mid-request
    halt = 1;
    step();
    halt = 0;
    step();
    chk("halt_pending", 32'(halted), 0);
    chk("halt_req", 32'(imem_req), 1);
    imem_ack = 1; exp_q.push_back(32'h0);
    step();
    imem_ack = 0;
    chk("halted", 32'(halted), 1);
    chk("halt_noreq", 32'(imem_req), 0);
    chk("halt_pc", pc, 32'h4);
    jump = 1; jump_target = 32'h41; imem_ack = 1;
    step(); step();
    jump = 0; imem_ack = 0;
    chk("halt_ign_pc", pc, 32'h4);
    chk("halt_ign_mis", 32'(misalign_err), 1);
    chk("halt_stays", 32'(halted), 1);
    // reset from HALT, IDLE redirect under stall
    reset = 1; stall = 1;
    step();
    reset = 0;
    chk("rst2_halted", 32'(halted), 0);
    chk("rst2_mis", 32'(misalign_err), 0);
    branch_taken = 1; branch_target = 32'h80;
    step();
    branch_taken = 0;
    chk("idle_redir_pc", pc, 32'h80);
    chk("idle_redir_req", 32'(imem_req), 0);
    stall = 0;
    step();
    chk("req_again", 32'(imem_req), 1);
    // reset while a request is outstanding drops it
    reset = 1; imem_ack = 1;
    step();
    reset = 0; imem_ack = 0;
    chk("rstreq_req", 32'(imem_req), 0);
    chk("rstreq_pc", pc, 32'h0);
    step();
    chk("rstreq_fd", 32'(fetch_done), 0);
    step();
    chk("sb_drained", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
